rc_model: RTL
=============

RC_MODEL -- requirements
Module: rc_model

Interface
REQ-001 The block SHALL have parameter WIDTH, default 18, meaning the signed fixed-point width of v_in and v_out.
REQ-002 The block SHALL have parameter FRAC, default 14, meaning the fraction bits of v_in, v_out and ALPHA_Q, so 1.0 = 16384.
REQ-003 The block SHALL have parameter ALPHA_Q, default 1559, meaning unsigned step coefficient alpha = ALPHA_Q/2^FRAC = 1-exp(-dt/tau) for dt=0.1us and tau=1us; legal range 1..2^FRAC-1.
REQ-004 The block SHALL have parameter V_INIT, default 0, meaning the reset value of v_out.
REQ-005 The block SHALL have parameter SETTLE_TOL, default 16, meaning the settle window in LSB.
REQ-006 The block SHALL have parameter SETTLE_CNT, default 8, meaning the consecutive in-window steps required to assert settled.
REQ-007 The block SHALL have port emu_clk, input, 1 bit: emulation clock, the single clock; all state updates on its rising edge.
REQ-008 The block SHALL have port emu_rst, input, 1 bit: reset, synchronous and active-high.
REQ-009 The block SHALL have port emu_stall, input, 1 bit: when high, hold all state for this cycle.
REQ-010 The block SHALL have port v_in, input, WIDTH bits, signed: filter input driven by the stimulus controller.
REQ-011 The block SHALL have port v_out, output, WIDTH bits, signed, registered: filter output.
REQ-012 The block SHALL have port n_steps, output, 32 bits, registered: count of completed time steps.
REQ-013 The block SHALL have port settled, output, 1 bit, registered: v_out within SETTLE_TOL of v_in for SETTLE_CNT steps.

Function
REQ-014 Each cycle with emu_rst=0 and emu_stall=0 SHALL be one time step dt.
REQ-015 On each time step, diff = v_in - v_out SHALL be computed at WIDTH+1 bits signed, with no overflow.
REQ-016 On each time step, prod = diff * ALPHA_Q SHALL be computed at full precision, WIDTH+FRAC+2 bits signed.
REQ-017 On each time step, delta = prod arithmetically shifted right by FRAC (floor), and v_out SHALL load v_out + delta truncated to WIDTH bits.
REQ-018 v_out SHALL change only on a time step, with one-cycle latency from v_in to the updated v_out.
REQ-019 Because 0 < alpha < 1, v_out SHALL stay within [min(v_out, v_in), max(v_out, v_in)] after each step, with no wrap for any legal input.
REQ-020 n_steps SHALL increment by 1 on each time step and wrap from 2^32-1 to 0.
REQ-021 When emu_stall=1, v_out, n_steps, the settle counter and settled SHALL all hold their values.
REQ-022 If v_in changes during a stall, it SHALL take effect on the first step after emu_stall falls.

Reset
REQ-023 When emu_rst=1 at a clock edge, v_out SHALL be V_INIT, n_steps SHALL be 0, the settle counter SHALL be 0 and settled SHALL be 0 after that edge.
REQ-024 emu_rst SHALL override emu_stall.
REQ-025 A reset asserted mid-run SHALL discard all filter state, with no residual from prior steps.
REQ-026 The first time step after reset release SHALL use v_out = V_INIT.

Configuration
REQ-027 With macro RC_SETTLE_DET_EN defined, the settle counter, ceil(log2(SETTLE_CNT+1)) bits, SHALL be implemented.
REQ-028 With RC_SETTLE_DET_EN defined, on each step the counter SHALL clear when |diff| > SETTLE_TOL and otherwise increment, saturating at SETTLE_CNT.
REQ-029 With RC_SETTLE_DET_EN defined, settled SHALL be registered as (next counter value == SETTLE_CNT), and |diff| == SETTLE_TOL SHALL count as in-window.
REQ-030 With RC_SETTLE_DET_EN undefined, no settle logic SHALL be instantiated, settled SHALL be constant 0, and the port list SHALL be unchanged.

Verification
REQ-031 Reset, then v_in=16384 with no stall: after 1 step v_out=1559 and n_steps=1.
REQ-032 Continuing with v_in=16384: after 10 steps v_out=16384*(1-exp(-1))=10357 +/-20 LSB; after 25 steps v_out=16384*(1-exp(-2.5))=15039 +/-20 LSB.
REQ-033 At step 5, hold emu_stall=1 for 3 cycles: v_out and n_steps are frozen; the step-6 value equals the unstalled step-6 value and n_steps=6.
REQ-034 With RC_SETTLE_DET_EN defined, v_in=16384 held: settled rises exactly SETTLE_CNT=8 steps after |diff|<=16 first holds; then changing v_in to -16384 drops settled on the next step.
REQ-035 Assert emu_rst for 1 cycle mid-run at v_out about 12000: next cycle v_out=0, n_steps=0 and settled=0, and step 1 after release gives v_out=1559 again.
REQ-036 Load n_steps to 2^32-1 by forced step count, apply one step: n_steps=0 with v_out updated normally.

Source files
------------

// File: rtl/rc_model.sv
// rc_model: first-order RC low-pass filter for emulation.
// Each unstalled cycle is one time step:
//   v_out <= v_out + floor((v_in - v_out) * ALPHA_Q / 2^FRAC)
// Optional settle detector is compiled in with macro RC_SETTLE_DET_EN;
// without it, settled is tied low and the port list is the same.
module rc_model #(
    parameter int          WIDTH      = 18,
    parameter int          FRAC       = 14,
    parameter int unsigned ALPHA_Q    = 1559,
    parameter int          V_INIT     = 0,
    parameter int unsigned SETTLE_TOL = 16,
    parameter int unsigned SETTLE_CNT = 8
) (
    input  logic                    emu_clk,
    input  logic                    emu_rst,
    input  logic                    emu_stall,
    input  logic signed [WIDTH-1:0] v_in,
    output logic signed [WIDTH-1:0] v_out,
    output logic [31:0]             n_steps,
    output logic                    settled
);

    localparam int unsigned DW = WIDTH + 1;          // difference width
    localparam int unsigned AW = FRAC + 1;           // coefficient as a positive signed value
    localparam int unsigned PW = WIDTH + FRAC + 2;   // full-precision product width

    localparam logic signed [AW-1:0]    ALPHA_S     = AW'(ALPHA_Q);
    localparam logic signed [WIDTH-1:0] V_INIT_S    = WIDTH'(V_INIT);

    // Reject a coefficient outside (0,1) or a zero settle count at elaboration
    if (ALPHA_Q < 1 || ALPHA_Q >= (1 << FRAC) || SETTLE_CNT < 1 || SETTLE_TOL >= (1 << WIDTH))
    begin : g_bad_cfg
        $error("rc_model: illegal parameter configuration");
    end

    logic signed [WIDTH-1:0] v_out_q, v_out_d;
    logic [31:0]             n_steps_q, n_steps_d;
    logic signed [DW-1:0]    diff_c;
    logic signed [PW-1:0]    prod_c;

    // Error term and its scaled step; the product cannot overflow PW bits
    always_comb begin
        diff_c = DW'(v_in) - DW'(v_out_q);
        prod_c = PW'(diff_c) * PW'(ALPHA_S);
    end

    // Next filter value and step count; a stall holds everything
    always_comb begin
        v_out_d   = v_out_q;
        n_steps_d = n_steps_q;
        if (!emu_stall) begin
            v_out_d   = WIDTH'(PW'(v_out_q) + (prod_c >>> FRAC));
            n_steps_d = n_steps_q + 32'd1;
        end
    end

    // Filter state registers, synchronous reset overrides stall
    always_ff @(posedge emu_clk) begin
        if (emu_rst) begin
            v_out_q   <= V_INIT_S;
            n_steps_q <= '0;
        end else begin
            v_out_q   <= v_out_d;
            n_steps_q <= n_steps_d;
        end
    end

    assign v_out   = v_out_q;
    assign n_steps = n_steps_q;

`ifdef RC_SETTLE_DET_EN
    localparam int unsigned CW = $clog2(SETTLE_CNT + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          settled_q, settled_d;
    logic [DW-1:0] abs_c;

    // Count consecutive in-window steps, saturating at SETTLE_CNT
    always_comb begin
        cnt_d     = cnt_q;
        settled_d = settled_q;
        abs_c     = diff_c[DW-1] ? DW'(-diff_c) : DW'(diff_c);
        if (!emu_stall) begin
            if (abs_c > DW'(SETTLE_TOL)) begin
                cnt_d = '0;
            end else if (cnt_q < CW'(SETTLE_CNT)) begin
                cnt_d = cnt_q + CW'(1);
            end
            settled_d = (cnt_d == CW'(SETTLE_CNT));
        end
    end

    // Settle detector registers
    always_ff @(posedge emu_clk) begin
        if (emu_rst) begin
            cnt_q     <= '0;
            settled_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            settled_q <= settled_d;
        end
    end

    assign settled = settled_q;
`else
    assign settled = 1'b0;
`endif

endmodule
